// File: rtl/rc_ctu_sched.sv
// Sequences LCU-level rate control across a frame in CTU raster order, one RC run per CTU.
// Optional RUN watchdog enabled by defining RC_SCHED_TIMEOUT_EN.
module rc_ctu_sched #(
    parameter int X_W     = 8,
    parameter int Y_W     = 8,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start_i,
    input  logic [X_W-1:0] pic_w_ctu_i,
    input  logic [Y_W-1:0] pic_h_ctu_i,
    input  logic           bit_vld_i,
    input  logic [15:0]    bitnum_i,
    input  logic           mod_vld_i,
    input  logic [27:0]    modebest_i,
    output logic           rc_start_o,
    input  logic           rc_done_i,
    input  logic [5:0]     rc_qp_i,
    output logic [X_W-1:0] rc_ctu_x_o,
    output logic [Y_W-1:0] rc_ctu_y_o,
    output logic [15:0]    rc_bitnum_o,
    output logic [27:0]    rc_modebest_o,
    output logic           qp_vld_o,
    output logic [5:0]     qp_o,
    input  logic           qp_rdy_i,
    output logic           busy_o,
    output logic           frame_done_o,
    output logic           err_timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
`ifdef RC_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [5:0]     QP_INIT = 6'd26;
    localparam logic [X_W-1:0] X_ONE   = X_W'(1'b1);
    localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1'b1);
    localparam logic [X_W-1:0] X_ZERO  = {X_W{1'b0}};
    localparam logic [Y_W-1:0] Y_ZERO  = {Y_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_IN = 3'd1,
        S_START   = 3'd2,
        S_RUN     = 3'd3,
        S_OUT     = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [X_W-1:0]   w_r;
    logic [Y_W-1:0]   h_r;
    logic [X_W-1:0]   x_r;
    logic [Y_W-1:0]   y_r;
    logic             bit_flg_r;
    logic             mod_flg_r;
    logic [15:0]      bit_buf_r;
    logic [27:0]      mod_buf_r;
    logic [15:0]      rc_bitnum_r;
    logic [27:0]      rc_modebest_r;
    logic [5:0]       qp_r;
    logic [5:0]       last_qp_r;
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;
    logic             rc_start_r;
    logic             qp_vld_r;
    logic             busy_r;
    logic             frame_done_r;

    logic             first_ctu_s;
    logic             last_x_s;
    logic             last_y_s;
    logic             bit_rdy_s;
    logic             mod_rdy_s;
    logic             launch_s;
    logic             consume_s;
    logic             frame_go_s;
    logic             timeout_s;

    assign first_ctu_s = (x_r == X_ZERO) && (y_r == Y_ZERO);
    assign last_x_s    = (x_r == (w_r - X_ONE));
    assign last_y_s    = (y_r == (h_r - Y_ONE));
    assign bit_rdy_s   = bit_flg_r | bit_vld_i;
    assign mod_rdy_s   = mod_flg_r | mod_vld_i;
    assign frame_go_s  = (state_r == S_IDLE) && start_i;
    assign launch_s    = (state_r == S_WAIT_IN) && (state_nxt_s == S_START);
    // CTU (0,0) has no predecessor, so it launches without consuming captured inputs
    assign consume_s   = launch_s && !first_ctu_s;
    assign timeout_s   = TO_EN && (state_r == S_RUN) && (cnt_r == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_i) state_nxt_s = S_WAIT_IN;
                else         state_nxt_s = S_IDLE;
            end
            S_WAIT_IN: begin
                if (first_ctu_s || (bit_rdy_s && mod_rdy_s)) state_nxt_s = S_START;
                else                                         state_nxt_s = S_WAIT_IN;
            end
            S_START: state_nxt_s = S_RUN;
            S_RUN: begin
                if (rc_done_i || timeout_s) state_nxt_s = S_OUT;
                else                        state_nxt_s = S_RUN;
            end
            S_OUT: begin
                if (qp_rdy_i) state_nxt_s = S_NEXT;
                else          state_nxt_s = S_OUT;
            end
            S_NEXT: begin
                if (last_x_s && last_y_s) state_nxt_s = S_DONE;
                else                      state_nxt_s = S_WAIT_IN;
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Picture dimensions latched at frame start, zero treated as one
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_r <= X_ZERO;
            h_r <= Y_ZERO;
        end else if (frame_go_s) begin
            w_r <= (pic_w_ctu_i == X_ZERO) ? X_ONE : pic_w_ctu_i;
            h_r <= (pic_h_ctu_i == Y_ZERO) ? Y_ONE : pic_h_ctu_i;
        end
    end

    // Raster CTU coordinates; held on the last CTU so they never exceed dims-1
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_r <= X_ZERO;
            y_r <= Y_ZERO;
        end else if (frame_go_s || (state_r == S_DONE)) begin
            x_r <= X_ZERO;
            y_r <= Y_ZERO;
        end else if ((state_r == S_NEXT) && !(last_x_s && last_y_s)) begin
            if (last_x_s) begin
                x_r <= X_ZERO;
                y_r <= y_r + Y_ONE;
            end else begin
                x_r <= x_r + X_ONE;
            end
        end
    end

    // Sticky input capture; first value wins, early arrivals are kept for the next CTU
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_flg_r <= 1'b0;
            mod_flg_r <= 1'b0;
            bit_buf_r <= 16'd0;
            mod_buf_r <= 28'd0;
        end else if ((state_r == S_IDLE) || consume_s) begin
            bit_flg_r <= 1'b0;
            mod_flg_r <= 1'b0;
        end else begin
            if (bit_vld_i && !bit_flg_r) begin
                bit_flg_r <= 1'b1;
                bit_buf_r <= bitnum_i;
            end
            if (mod_vld_i && !mod_flg_r) begin
                mod_flg_r <= 1'b1;
                mod_buf_r <= modebest_i;
            end
        end
    end

    // RC operands, loaded at launch and held while RC runs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rc_bitnum_r   <= 16'd0;
            rc_modebest_r <= 28'd0;
        end else if (launch_s) begin
            if (first_ctu_s) begin
                rc_bitnum_r   <= 16'd0;
                rc_modebest_r <= 28'd0;
            end else begin
                rc_bitnum_r   <= bit_flg_r ? bit_buf_r : bitnum_i;
                rc_modebest_r <= mod_flg_r ? mod_buf_r : modebest_i;
            end
        end
    end

    // QP capture; on watchdog expiry the last accepted QP is reissued
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            qp_r      <= 6'd0;
            last_qp_r <= QP_INIT;
        end else begin
            if (frame_go_s) begin
                last_qp_r <= QP_INIT;
            end else if ((state_r == S_OUT) && qp_rdy_i) begin
                last_qp_r <= qp_r;
            end
            if ((state_r == S_RUN) && rc_done_i) begin
                qp_r <= rc_qp_i;
            end else if (timeout_s) begin
                qp_r <= last_qp_r;
            end
        end
    end

    // RUN cycle counter and sticky timeout flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {CNT_W{1'b0}};
            err_r <= 1'b0;
        end else begin
            if (state_r != S_RUN) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r != CNT_W'(TIMEOUT - 1)) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
            if (timeout_s && !rc_done_i) begin
                err_r <= 1'b1;
            end
        end
    end

    // Control outputs registered from the next state so they align with the state itself
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rc_start_r   <= 1'b0;
            qp_vld_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            rc_start_r   <= (state_nxt_s == S_START);
            qp_vld_r     <= (state_nxt_s == S_OUT);
            busy_r       <= (state_nxt_s != S_IDLE);
            frame_done_r <= (state_nxt_s == S_DONE);
        end
    end

    assign rc_start_o    = rc_start_r;
    assign rc_ctu_x_o    = x_r;
    assign rc_ctu_y_o    = y_r;
    assign rc_bitnum_o   = rc_bitnum_r;
    assign rc_modebest_o = rc_modebest_r;
    assign qp_vld_o      = qp_vld_r;
    assign qp_o          = qp_r;
    assign busy_o        = busy_r;
    assign frame_done_o  = frame_done_r;
    assign err_timeout_o = err_r;

endmodule

// File: tb/tb_rc_ctu_sched.sv
// Randomized self-checking bench for rc_ctu_sched; expectations come from raster-order
// arithmetic and first-value-wins input bookkeeping kept in the bench.
module tb_rc_ctu_sched;

    localparam int X_W     = 8;
    localparam int Y_W     = 8;
    localparam int TIMEOUT = 64;

    logic           clk = 1'b0;
    logic           rstn;
    logic           start_i;
    logic [X_W-1:0] pic_w_ctu_i;
    logic [Y_W-1:0] pic_h_ctu_i;
    logic           bit_vld_i;
    logic [15:0]    bitnum_i;
    logic           mod_vld_i;
    logic [27:0]    modebest_i;
    logic           rc_start_o;
    logic           rc_done_i;
    logic [5:0]     rc_qp_i;
    logic [X_W-1:0] rc_ctu_x_o;
    logic [Y_W-1:0] rc_ctu_y_o;
    logic [15:0]    rc_bitnum_o;
    logic [27:0]    rc_modebest_o;
    logic           qp_vld_o;
    logic [5:0]     qp_o;
    logic           qp_rdy_i;
    logic           busy_o;
    logic           frame_done_o;
    logic           err_timeout_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          last_qp;
    bit          err_model;
    bit          force31;
    bit          first_bit;
    bit          dup_en;
    int          sec;
    logic [15:0] nb;
    logic [15:0] dupb;
    logic [27:0] nm;
    logic [27:0] dupm;

    rc_ctu_sched #(.X_W(X_W), .Y_W(Y_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i),
        .pic_w_ctu_i(pic_w_ctu_i), .pic_h_ctu_i(pic_h_ctu_i),
        .bit_vld_i(bit_vld_i), .bitnum_i(bitnum_i),
        .mod_vld_i(mod_vld_i), .modebest_i(modebest_i),
        .rc_start_o(rc_start_o), .rc_done_i(rc_done_i), .rc_qp_i(rc_qp_i),
        .rc_ctu_x_o(rc_ctu_x_o), .rc_ctu_y_o(rc_ctu_y_o),
        .rc_bitnum_o(rc_bitnum_o), .rc_modebest_o(rc_modebest_o),
        .qp_vld_o(qp_vld_o), .qp_o(qp_o), .qp_rdy_i(qp_rdy_i),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .err_timeout_o(err_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        start_i    = 1'b0;
        bit_vld_i  = 1'b0;
        mod_vld_i  = 1'b0;
        rc_done_i  = 1'b0;
        bitnum_i   = 16'($urandom);
        modebest_i = 28'($urandom);
        rc_qp_i    = 6'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rc_start"}, rc_start_o, 0);
        check_eq({tag, "_x"}, rc_ctu_x_o, 0);
        check_eq({tag, "_y"}, rc_ctu_y_o, 0);
        check_eq({tag, "_bitnum"}, rc_bitnum_o, 0);
        check_eq({tag, "_modebest"}, rc_modebest_o, 0);
        check_eq({tag, "_qp_vld"}, qp_vld_o, 0);
        check_eq({tag, "_qp"}, qp_o, 0);
        check_eq({tag, "_busy"}, busy_o, 0);
        check_eq({tag, "_frame_done"}, frame_done_o, 0);
        check_eq({tag, "_err"}, err_timeout_o, 0);
    endtask

    // One input delivery: first kind at slot 0, other kind at slot sec, optional repeat at slot 1
    task automatic make_plan();
        first_bit = 1'($urandom_range(0, 1));
        sec       = $urandom_range(0, 5);
        dup_en    = (sec > 0) && ($urandom_range(0, 1) == 1);
        nb        = 16'($urandom);
        nm        = 28'($urandom);
        dupb      = nb ^ 16'h0fff;
        dupm      = nm ^ 28'h00fffff;
    endtask

    task automatic drive_slot(input int s);
        if (s == 0) begin
            if (first_bit) begin bit_vld_i = 1'b1; bitnum_i = nb; end
            else           begin mod_vld_i = 1'b1; modebest_i = nm; end
        end
        if (s == sec) begin
            if (first_bit) begin mod_vld_i = 1'b1; modebest_i = nm; end
            else           begin bit_vld_i = 1'b1; bitnum_i = nb; end
        end
        if (dup_en && s == 1) begin
            if (first_bit) begin bit_vld_i = 1'b1; bitnum_i = dupb; end
            else           begin mod_vld_i = 1'b1; modebest_i = dupm; end
        end
    endtask

    task automatic run_frame(input int w_in, input int h_in, input int abort_idx, input int to_idx);
        int w, h, n, d, spur, hold, g;
        bit early, timed;
        logic [5:0] q;
        w = (w_in == 0) ? 1 : w_in;
        h = (h_in == 0) ? 1 : h_in;
        n = w * h;
        last_qp = 26;
        pic_w_ctu_i = X_W'(w_in);
        pic_h_ctu_i = Y_W'(h_in);
        start_i = 1'b1;
        tick();
        clr_inputs();
        check_eq("busy_after_start", busy_o, 1);
        check_eq("no_launch_yet", rc_start_o, 0);
        tick();
        check_eq("rc_start_ctu0", rc_start_o, 1);
        check_eq("x_ctu0", rc_ctu_x_o, 0);
        check_eq("y_ctu0", rc_ctu_y_o, 0);
        check_eq("bitnum_ctu0", rc_bitnum_o, 0);
        check_eq("modebest_ctu0", rc_modebest_o, 0);
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == abort_idx) begin
                rstn = 1'b0;
                #1;
                check_all_zero("abort");
                err_model = 1'b0;
                tick();
                rstn = 1'b1;
                tick();
                return;
            end
            timed = 1'b0;
            early = (i < n - 1) && (i != to_idx) && ($urandom_range(0, 1) == 1);
            if (i == to_idx) begin
`ifdef RC_SCHED_TIMEOUT_EN
                repeat (TIMEOUT - 1) begin
                    check_eq("run_wait_qp_vld", qp_vld_o, 0);
                    tick();
                end
                check_eq("last_run_qp_vld", qp_vld_o, 0);
                tick();
                q = 6'(last_qp);
                err_model = 1'b1;
                rc_done_i = 1'b1;
                rc_qp_i = q ^ 6'h15;
                check_eq("to_qp_vld", qp_vld_o, 1);
                check_eq("to_qp", qp_o, q);
                check_eq("to_err", err_timeout_o, 1);
                tick();
                clr_inputs();
                timed = 1'b1;
`else
                repeat (100) tick();
                check_eq("stall_qp_vld", qp_vld_o, 0);
                check_eq("stall_err", err_timeout_o, 0);
`endif
            end else begin
                if (early) make_plan();
                d = early ? sec + 1 + $urandom_range(0, 3) : $urandom_range(1, 4);
                spur = $urandom_range(0, d - 1);
                for (int j = 0; j < d; j++) begin
                    if (j == spur) begin
                        start_i = 1'b1;
                        pic_w_ctu_i = X_W'($urandom);
                        pic_h_ctu_i = Y_W'($urandom);
                    end
                    if (early && j <= sec) drive_slot(j);
                    check_eq("run_qp_vld", qp_vld_o, 0);
                    check_eq("run_x", rc_ctu_x_o, i % w);
                    check_eq("run_y", rc_ctu_y_o, i / w);
                    tick();
                    clr_inputs();
                end
            end
            if (!timed) begin
                q = (force31 && i == 0) ? 6'd31 : 6'($urandom_range(0, 63));
                rc_done_i = 1'b1;
                rc_qp_i = q;
                tick();
                clr_inputs();
                check_eq("qp_vld", qp_vld_o, 1);
                check_eq("qp", qp_o, q);
            end
            hold = (force31 && i == 0) ? 10 : $urandom_range(0, 4);
            for (int k = 0; k < hold; k++) begin
                check_eq("hold_qp_vld", qp_vld_o, 1);
                check_eq("hold_qp", qp_o, q);
                check_eq("hold_x", rc_ctu_x_o, i % w);
                check_eq("hold_y", rc_ctu_y_o, i / w);
                tick();
            end
            qp_rdy_i = 1'b1;
            check_eq("hs_qp_vld", qp_vld_o, 1);
            tick();
            qp_rdy_i = 1'b0;
            last_qp = int'(q);
            check_eq("post_hs_qp_vld", qp_vld_o, 0);
            if (i == n - 1) begin
                tick();
                check_eq("frame_done", frame_done_o, 1);
                tick();
                check_eq("frame_done_pulse", frame_done_o, 0);
                check_eq("busy_end", busy_o, 0);
                check_eq("x_end", rc_ctu_x_o, 0);
                check_eq("y_end", rc_ctu_y_o, 0);
                check_eq("err_end", err_timeout_o, err_model);
            end else begin
                tick();
                if (early) begin
                    check_eq("wait_preset_no_launch", rc_start_o, 0);
                    tick();
                end else begin
                    g = $urandom_range(0, 3);
                    for (int k = 0; k < g; k++) begin
                        if ($urandom_range(0, 1) == 1) rc_done_i = 1'b1;
                        check_eq("wait_no_launch", rc_start_o, 0);
                        tick();
                        clr_inputs();
                    end
                    make_plan();
                    for (int s = 0; s <= sec; s++) begin
                        drive_slot(s);
                        check_eq("wait_in_no_launch", rc_start_o, 0);
                        tick();
                        clr_inputs();
                    end
                end
                check_eq("rc_start", rc_start_o, 1);
                check_eq("x", rc_ctu_x_o, (i + 1) % w);
                check_eq("y", rc_ctu_y_o, (i + 1) / w);
                check_eq("bitnum", rc_bitnum_o, nb);
                check_eq("modebest", rc_modebest_o, nm);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        qp_rdy_i = 1'b0;
        err_model = 1'b0;
        force31 = 1'b0;
        pic_w_ctu_i = '0;
        pic_h_ctu_i = '0;
        clr_inputs();
        tick();
        tick();
        check_all_zero("reset");
        rstn = 1'b1;
        tick();
        force31 = 1'b1;
        run_frame(3, 2, -1, -1);
        force31 = 1'b0;
        run_frame(1, 1, -1, -1);
        run_frame(0, 0, -1, -1);
        for (int f = 0; f < 4; f++) begin
            run_frame($urandom_range(0, 4), $urandom_range(0, 3), -1, -1);
        end
        run_frame(2, 2, -1, 1);
        run_frame(3, 3, 4, -1);
        check_all_zero("post_abort");
        run_frame(2, 1, -1, -1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
